ptch_pid_cntrl: RTL and testbench
=================================

# ptch_pid_cntrl

Balance controller stage directly downstream of the inertial interface. It consumes the integrated pitch (`ptch`) and its `vld` strobe, and computes a saturated PID term: P on pitch error, I from a vld-qualified accumulator, D from a two-sample history. It then applies load-cell steering and drives the left/right motor speed commands, with a one-cycle `out_vld` pulse, to the motor-drive logic. The datapath is a fixed 3-stage pipeline that accepts a new sample every cycle.

## Interface
- `P_COEFF`, default 5'sd12: signed proportional gain.
- `D_COEFF`, default 6'sd20: signed derivative gain.
- `FAST_THRESH`, default 12'sd1536: `too_fast` threshold on speed commands.
- `clk`, input, 1: system clock. The block uses one clock.
- `rst_n`, input, 1: reset. Reset is synchronous and active-low.
- `vld`, input, 1: new `ptch` sample strobe, one cycle wide.
- `ptch`, input, 16: signed pitch.
- `pwr_up`, input, 1: motor enable. When low, speed outputs are forced to 0.
- `rider_off`, input, 1: clears the integrator.
- `en_steer`, input, 1: enables the steering term.
- `ld_cell_diff`, input, 12: signed load-cell difference.
- `lft_spd`, output, 12: signed left speed command.
- `rgt_spd`, output, 12: signed right speed command.
- `too_fast`, output, 1: `lft_spd` or `rgt_spd` > `FAST_THRESH`.
- `out_vld`, output, 1: outputs updated this cycle, one-cycle pulse.

## Operation
- Stage 1 (on `vld`):
  - `err` = `ptch` saturated to 10-bit signed [-512, 511].
  - History shift: `prev2 <= prev1`, `prev1 <= err`. History reset value is 0.
  - Integrator `integ` is 18-bit signed. Add sign-extended `err`.
  - On signed overflow (operand signs equal, result sign differs), `integ` holds its old value.
  - `rider_off` high clears `integ` to 0. This takes priority over accumulation and applies whether or not `vld` is high.
- Stage 2:
  - `P` = `err` * `P_COEFF`, 15-bit signed.
  - `I` = `integ` >>> 6, 12-bit signed. Uses the value that includes the current sample.
  - `D` = sat7(`err` − `prev2`) * `D_COEFF`. The difference is computed as 11-bit, then saturated to [-64, 63]. Product is 13-bit signed.
  - `pid` = `P` + `I` + `D`, each sign-extended to 16 bits. `pid` is registered.
- Stage 3:
  - `steer` = `en_steer` ? (`ld_cell_diff` >>> 3) : 0, sign-extended to 16 bits.
  - `lft` = `pid` − `steer`.
  - `rgt` = `pid` + `steer`.
  - Each is saturated to 12-bit signed [-2048, 2047].
  - `pwr_up` low forces both outputs to 0. `too_fast` is computed on the registered values.
- Pipeline valid bits `v1`, `v2`, `v3` track `vld` through the stages. `out_vld` = `v3`.
- Outputs update only when a stage-3 result arrives. Otherwise they hold.
- No backpressure: the block accepts `vld` every cycle.

## Timing
- Reset (`rst_n` low at a clock edge) zeroes everything:
  - `integ`, history, all pipeline registers and valid bits.
  - `lft_spd` = 0, `rgt_spd` = 0, `too_fast` = 0, `out_vld` = 0.
- Latency: `vld` high in cycle N produces `out_vld` high in cycle N+3, with outputs valid that same cycle.
- Back-to-back `vld` in N and N+1 produces `out_vld` in N+3 and N+4, each with its own result.
- Reset mid-pipeline discards in-flight samples. No `out_vld` follows for them.
- `rider_off` and `vld` in the same cycle: `integ` = 0 and the history still shifts. `I` = 0 for that sample.
- `pwr_up` is sampled at stage 3. `out_vld` still pulses when `pwr_up` is low.
- Saturation boundaries are exact:
  - `ptch` = 511 passes through as 511; `ptch` = 512 yields 511.
  - `ptch` = −512 passes through; `ptch` = −513 yields −512.

## Structure
- Package `segway_pkg`:
  - Default coefficients.
  - `FAST_THRESH`.
  - Width constants: `ERR_W` = 10, `INTEG_W` = 18, `DDIFF_W` = 7, `SPD_W` = 12.
- Sub-module `signed_sat`: parameterized IN_W → OUT_W signed saturator. It is instantiated for `err`, the D difference, `lft` and `rgt`.

## Test plan
- Reset: hold `rst_n` low for 2 cycles with `vld` toggling → all outputs 0, no `out_vld`, no `out_vld` in the following 5 cycles.
- After reset, with `pwr_up` = 1 and `en_steer` = 0, send one `vld` with `ptch` = 16 → `out_vld` at N+3, `lft_spd` = `rgt_spd` = 512 (P 192, I 0, D 320), `too_fast` = 0.
- One `vld` with `ptch` = 16'h7FFF → `err` 511, `pid` 7399, `lft_spd` = `rgt_spd` = 2047, `too_fast` = 1.
- 300 consecutive `vld` pulses with `ptch` = 511 → `integ` = 130816 after 256 pulses and held thereafter (`I` = 2044). Then `rider_off` plus `vld` with `ptch` = 0 → `integ` = 0.
- From reset, `en_steer` = 1, `ld_cell_diff` = 80, `ptch` = 0, send `vld` → `lft_spd` = −10, `rgt_spd` = +10. Repeat with `pwr_up` = 0 → both 0 and `out_vld` still pulses.
- Assert `rst_n` low in cycle N+1 after a `vld` → no `out_vld` appears and outputs read 0.

Source files
------------

// File: rtl/segway_pkg.sv
// Shared widths, default gains and helpers for the pitch PID balance controller.
package segway_pkg;

    localparam int PTCH_W    = 16;
    localparam int ERR_W     = 10;
    localparam int INTEG_W   = 18;
    localparam int DDIFF_W   = 7;
    localparam int DIFF_W    = 11;
    localparam int SPD_W     = 12;
    localparam int LDC_W     = 12;
    localparam int P_W       = 15;
    localparam int I_W       = 12;
    localparam int D_W       = 13;
    localparam int PID_W     = 16;
    localparam int I_SHIFT   = 6;
    localparam int STEER_SHIFT = 3;
    localparam int P_COEFF_W = 5;
    localparam int D_COEFF_W = 6;

    localparam logic signed [P_COEFF_W-1:0] P_COEFF_DEF     = 5'sd12;
    localparam logic signed [D_COEFF_W-1:0] D_COEFF_DEF     = 6'sd20;
    localparam logic signed [SPD_W-1:0]     FAST_THRESH_DEF = 12'sd1536;

    // Two's-complement add overflow: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/ptch_pid_cntrl_if.sv
// Sample-in / speed-command-out bundle between the inertial front end, the PID and the motor drive.
interface ptch_pid_cntrl_if;
    import segway_pkg::*;

    logic                     vld;
    logic signed [PTCH_W-1:0] ptch;
    logic                     pwr_up;
    logic                     rider_off;
    logic                     en_steer;
    logic signed [LDC_W-1:0]  ld_cell_diff;
    logic signed [SPD_W-1:0]  lft_spd;
    logic signed [SPD_W-1:0]  rgt_spd;
    logic                     too_fast;
    logic                     out_vld;

    modport master (
        output vld, ptch, pwr_up, rider_off, en_steer, ld_cell_diff,
        input  lft_spd, rgt_spd, too_fast, out_vld
    );

    modport slave (
        input  vld, ptch, pwr_up, rider_off, en_steer, ld_cell_diff,
        output lft_spd, rgt_spd, too_fast, out_vld
    );

endinterface

// File: rtl/signed_sat.sv
// Signed saturator: clamps a two's-complement value from IN_W bits down to OUT_W bits.
module signed_sat #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 10
) (
    input  logic signed [IN_W-1:0]  i_din,
    output logic signed [OUT_W-1:0] o_dout
);
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [IN_W-OUT_W:0] w_top;
    logic                w_pos_ovf;
    logic                w_neg_ovf;

    // In range only when every bit from the output sign bit upward is identical.
    assign w_top     = i_din[IN_W-1:OUT_W-1];
    assign w_pos_ovf = ~i_din[IN_W-1] & (|w_top);
    assign w_neg_ovf =  i_din[IN_W-1] & ~(&w_top);

    always_comb begin
        o_dout = i_din[OUT_W-1:0];
        if (w_pos_ovf) begin
            o_dout = OUT_MAX;
        end else if (w_neg_ovf) begin
            o_dout = OUT_MIN;
        end
    end

endmodule

// File: rtl/ptch_pid_cntrl.sv
// Three-stage pitch PID with load-cell steering; produces saturated left/right speed commands.
module ptch_pid_cntrl
    import segway_pkg::*;
#(
    parameter logic signed [P_COEFF_W-1:0] P_COEFF     = P_COEFF_DEF,
    parameter logic signed [D_COEFF_W-1:0] D_COEFF     = D_COEFF_DEF,
    parameter logic signed [SPD_W-1:0]     FAST_THRESH = FAST_THRESH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    ptch_pid_cntrl_if.slave  pid_if
);

    // Stage 1: error saturation, history, integrator
    logic signed [ERR_W-1:0]   w_err;
    logic signed [INTEG_W-1:0] w_integ_sum;
    logic                      w_integ_ovf;
    logic signed [ERR_W-1:0]   r_prev1;
    logic signed [ERR_W-1:0]   r_prev2;
    logic signed [ERR_W-1:0]   r_s1_err;
    logic signed [ERR_W-1:0]   r_s1_prv2;
    logic signed [INTEG_W-1:0] r_integ;
    logic                      r_v1;

    signed_sat #(.IN_W(PTCH_W), .OUT_W(ERR_W)) u_sat_err (
        .i_din  (pid_if.ptch),
        .o_dout (w_err)
    );

    assign w_integ_sum = r_integ + INTEG_W'(w_err);
    assign w_integ_ovf = add_ovf(r_integ[INTEG_W-1], w_err[ERR_W-1], w_integ_sum[INTEG_W-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev1   <= '0;
            r_prev2   <= '0;
            r_s1_err  <= '0;
            r_s1_prv2 <= '0;
            r_integ   <= '0;
            r_v1      <= 1'b0;
        end else begin
            r_v1 <= pid_if.vld;
            if (pid_if.vld) begin
                // D looks two samples back, so capture prev2 before the shift.
                r_s1_err  <= w_err;
                r_s1_prv2 <= r_prev2;
                r_prev1   <= w_err;
                r_prev2   <= r_prev1;
            end
            if (pid_if.rider_off) begin
                r_integ <= '0;
            end else if (pid_if.vld && !w_integ_ovf) begin
                r_integ <= w_integ_sum;
            end
        end
    end

    // Stage 2: P, I, D terms and their sum
    logic signed [P_W-1:0]     w_p;
    logic signed [I_W-1:0]     w_i;
    logic signed [DIFF_W-1:0]  w_ddiff;
    logic signed [DDIFF_W-1:0] w_ddiff_sat;
    logic signed [D_W-1:0]     w_d;
    logic signed [PID_W-1:0]   w_pid;
    logic signed [PID_W-1:0]   r_pid;
    logic                      r_v2;

    assign w_p = P_W'(r_s1_err) * P_W'(P_COEFF);
    // Taking the top I_W bits equals integ >>> I_SHIFT truncated to I_W.
    assign w_i = r_integ[INTEG_W-1:I_SHIFT];
    assign w_ddiff = DIFF_W'(r_s1_err) - DIFF_W'(r_s1_prv2);

    signed_sat #(.IN_W(DIFF_W), .OUT_W(DDIFF_W)) u_sat_ddiff (
        .i_din  (w_ddiff),
        .o_dout (w_ddiff_sat)
    );

    assign w_d   = D_W'(w_ddiff_sat) * D_W'(D_COEFF);
    assign w_pid = PID_W'(w_p) + PID_W'(w_i) + PID_W'(w_d);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pid <= '0;
            r_v2  <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_pid <= w_pid;
            end
        end
    end

    // Stage 3: steering, output saturation, power gating
    logic signed [LDC_W-1:0]  w_steer_sh;
    logic signed [PID_W-1:0]  w_steer;
    logic signed [PID_W:0]    w_lft_raw;
    logic signed [PID_W:0]    w_rgt_raw;
    logic signed [SPD_W-1:0]  w_lft_sat;
    logic signed [SPD_W-1:0]  w_rgt_sat;
    logic signed [SPD_W-1:0]  r_lft;
    logic signed [SPD_W-1:0]  r_rgt;
    logic                     r_v3;

    assign w_steer_sh = pid_if.ld_cell_diff >>> STEER_SHIFT;
    assign w_steer    = pid_if.en_steer ? PID_W'(w_steer_sh) : '0;
    assign w_lft_raw  = (PID_W+1)'(r_pid) - (PID_W+1)'(w_steer);
    assign w_rgt_raw  = (PID_W+1)'(r_pid) + (PID_W+1)'(w_steer);

    signed_sat #(.IN_W(PID_W+1), .OUT_W(SPD_W)) u_sat_lft (
        .i_din  (w_lft_raw),
        .o_dout (w_lft_sat)
    );

    signed_sat #(.IN_W(PID_W+1), .OUT_W(SPD_W)) u_sat_rgt (
        .i_din  (w_rgt_raw),
        .o_dout (w_rgt_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lft <= '0;
            r_rgt <= '0;
            r_v3  <= 1'b0;
        end else begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_lft <= pid_if.pwr_up ? w_lft_sat : '0;
                r_rgt <= pid_if.pwr_up ? w_rgt_sat : '0;
            end
        end
    end

    assign pid_if.lft_spd  = r_lft;
    assign pid_if.rgt_spd  = r_rgt;
    assign pid_if.out_vld  = r_v3;
    assign pid_if.too_fast = (r_lft > FAST_THRESH) || (r_rgt > FAST_THRESH);

endmodule

// File: tb/tb_ptch_pid_cntrl.sv
// Directed bench for ptch_pid_cntrl: hand-computed vectors checked with immediate assertions.
module tb_ptch_pid_cntrl;
    import segway_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ptch_pid_cntrl_if bus ();

    ptch_pid_cntrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pid_if (bus)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int l, input int r, input int tf);
        chk({tag, "_lft"}, 32'(bus.lft_spd), l);
        chk({tag, "_rgt"}, 32'(bus.rgt_spd), r);
        chk({tag, "_tf"},  32'(bus.too_fast), tf);
        $display("txn %s out_vld=%0d lft=%0d rgt=%0d too_fast=%0d",
                 tag, bus.out_vld, bus.lft_spd, bus.rgt_spd, bus.too_fast);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.vld = 1'b0;
        bus.rider_off = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Single sample with exact latency check: out_vld only in cycle N+3.
    task automatic one_txn(input string tag, input logic signed [15:0] p, input logic ro,
                           input int l, input int r, input int tf);
        bus.vld = 1'b1;
        bus.ptch = p;
        bus.rider_off = ro;
        tick();
        bus.vld = 1'b0;
        bus.rider_off = 1'b0;
        chk({tag, "_vld_n1"}, 32'(bus.out_vld), 0);
        tick();
        chk({tag, "_vld_n2"}, 32'(bus.out_vld), 0);
        tick();
        chk({tag, "_vld_n3"}, 32'(bus.out_vld), 1);
        chk_outs(tag, l, r, tf);
        tick();
        chk({tag, "_vld_n4"}, 32'(bus.out_vld), 0);
    endtask

    // n back-to-back samples of the same pitch; checks the result of the last one.
    task automatic stream(input string tag, input logic signed [15:0] p, input int n,
                          input int l, input int r, input int tf);
        for (int k = 0; k < n; k++) begin
            bus.vld = 1'b1;
            bus.ptch = p;
            tick();
        end
        bus.vld = 1'b0;
        tick();
        tick();
        chk({tag, "_vld"}, 32'(bus.out_vld), 1);
        chk_outs(tag, l, r, tf);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.vld = 1'b0;
        bus.ptch = 16'sd100;
        bus.pwr_up = 1'b1;
        bus.rider_off = 1'b0;
        bus.en_steer = 1'b0;
        bus.ld_cell_diff = '0;

        // Reset with vld toggling, then quiet cycles
        for (int k = 0; k < 2; k++) begin
            bus.vld = ~bus.vld;
            tick();
            chk("rst_out_vld", 32'(bus.out_vld), 0);
            chk("rst_lft", 32'(bus.lft_spd), 0);
            chk("rst_rgt", 32'(bus.rgt_spd), 0);
            chk("rst_tf", 32'(bus.too_fast), 0);
        end
        rst_n = 1'b1;
        bus.vld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("post_rst_out_vld", 32'(bus.out_vld), 0);
        end

        // P 192 + I 0 + D 320
        one_txn("ptch16", 16'sd16, 1'b0, 512, 512, 0);

        // err 511: P 6132 + I 7 + D 1260 = 7399
        do_reset();
        one_txn("ptch_max", 16'sh7FFF, 1'b0, 2047, 2047, 1);

        // err -512: P -6144 + I -8 + D -1280, negative clamp does not trip too_fast
        do_reset();
        one_txn("ptch_neg", -16'sd513, 1'b0, -2048, -2048, 0);

        // Saturation boundaries observed through the integrator: 64 samples, then read I alone
        do_reset();
        stream("sat511_load", 16'sd511, 64, 2047, 2047, 1);
        stream("sat511_read", 16'sd0, 3, 511, 511, 0);
        do_reset();
        stream("sat512_load", 16'sd512, 64, 2047, 2047, 1);
        stream("sat512_read", 16'sd0, 3, 511, 511, 0);
        do_reset();
        stream("satm512_load", -16'sd512, 64, -2048, -2048, 0);
        stream("satm512_read", 16'sd0, 3, -512, -512, 0);
        do_reset();
        stream("satm513_load", -16'sd513, 64, -2048, -2048, 0);
        stream("satm513_read", 16'sd0, 3, -512, -512, 0);

        // Integrator holds at 130816 (I 2044) on overflow; rider_off clears it
        do_reset();
        stream("integ300", 16'sd511, 300, 2047, 2047, 1);
        one_txn("integ_hold_a", 16'sd0, 1'b0, 764, 764, 0);
        one_txn("integ_hold_b", 16'sd0, 1'b0, 764, 764, 0);
        one_txn("rider_off", 16'sd0, 1'b1, 0, 0, 0);
        one_txn("after_clear", 16'sd0, 1'b0, 0, 0, 0);

        // Back-to-back samples each carry their own result
        do_reset();
        bus.vld = 1'b1;
        bus.ptch = 16'sd16;
        tick();
        bus.ptch = 16'sd32;
        tick();
        bus.ptch = 16'sd48;
        tick();
        bus.vld = 1'b0;
        chk("b2b_vld0", 32'(bus.out_vld), 1);
        chk_outs("b2b_s0", 512, 512, 0);
        tick();
        chk("b2b_vld1", 32'(bus.out_vld), 1);
        chk_outs("b2b_s1", 1024, 1024, 0);
        tick();
        chk("b2b_vld2", 32'(bus.out_vld), 1);
        chk_outs("b2b_s2", 1217, 1217, 0);
        tick();
        chk("b2b_vld_end", 32'(bus.out_vld), 0);

        // Steering and power gating
        do_reset();
        bus.en_steer = 1'b1;
        bus.ld_cell_diff = 12'sd80;
        one_txn("steer_pos", 16'sd0, 1'b0, -10, 10, 0);
        bus.ld_cell_diff = -12'sd80;
        one_txn("steer_neg", 16'sd0, 1'b0, 10, -10, 0);
        bus.ld_cell_diff = 12'sd80;
        bus.pwr_up = 1'b0;
        one_txn("pwr_off", 16'sd0, 1'b0, 0, 0, 0);
        bus.pwr_up = 1'b1;
        bus.en_steer = 1'b0;
        bus.ld_cell_diff = '0;

        // Reset one cycle after vld discards the in-flight sample
        do_reset();
        one_txn("pre_flush", 16'sd16, 1'b0, 512, 512, 0);
        bus.vld = 1'b1;
        bus.ptch = 16'sd16;
        tick();
        bus.vld = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("flush_lft", 32'(bus.lft_spd), 0);
        chk("flush_rgt", 32'(bus.rgt_spd), 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("flush_out_vld", 32'(bus.out_vld), 0);
            chk("flush_lft_hold", 32'(bus.lft_spd), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
